// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and width defaults shared by the ALU scheduler
package alu_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF = 4;
  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SLT = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR = 4'h9;
  localparam logic [3:0] OP_SRL = 4'hA;
  localparam logic [3:0] OP_SRA = 4'hB;
  localparam logic [3:0] OP_XOR = 4'hC;
  localparam logic [3:0] OP_LAST = 4'hC;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
endpackage

// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: request, shared-ALU and response signals of the scheduler
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W = alu_pkg::DATA_W_DEF,
  parameter int OP_W = alu_pkg::OP_W_DEF,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] req_valid, req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result, rsp_result;
  logic [OP_W-1:0] alu_op;
  logic alu_exception, rsp_valid, rsp_ready, rsp_exception, rsp_zero;
  logic [ID_W-1:0] rsp_id;
  modport slave (
    input req_valid, req_a, req_b, req_op, alu_result, alu_exception, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_exception, rsp_zero
  );
  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, alu_exception, rsp_ready,
    input req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_exception, rsp_zero
  );
endinterface

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after last_grant_i
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [ID_W-1:0]    grant_idx_o
);
  logic [ID_W-1:0] idx;
  // scan farthest-first so the nearest requester after the pointer overwrites the rest
  always_comb begin
    grant_oh_o = '0;
    grant_idx_o = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (req_i[idx]) begin
        grant_oh_o = '0;
        grant_oh_o[idx] = 1'b1;
        grant_idx_o = idx;
      end
    end
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one combinational ALU with a tagged,
// back-pressured response channel
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W = OP_W_DEF,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic clk,
  input logic rst_n,
  alu_rr_scheduler_if.slave bus_if
);
  state_e state_q, state_d;
  logic [ID_W-1:0] last_q, id_q, gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [DATA_W-1:0] a_q, b_q, res_q, sel_a, sel_b;
  logic [OP_W-1:0] op_q, sel_op;
  logic exc_q, zero_q, hs, fault;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i(bus_if.req_valid),
    .last_grant_i(last_q),
    .grant_oh_o(gnt_oh),
    .grant_idx_o(gnt_idx)
  );
  assign sel_a = bus_if.req_a[gnt_idx*DATA_W +: DATA_W];
  assign sel_b = bus_if.req_b[gnt_idx*DATA_W +: DATA_W];
  assign sel_op = bus_if.req_op[gnt_idx*OP_W +: OP_W];
  assign hs = state_q == S_IDLE && |bus_if.req_valid;
  // faults never reach the ALU: answered directly with a zero result
  assign fault = sel_op > OP_W'(OP_LAST) || (sel_op == OP_W'(OP_DIV) && sel_b == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == S_IDLE ? (hs ? (fault ? S_RESP : S_EXEC) : S_IDLE)
            : state_q == S_EXEC ? S_RESP
            : bus_if.rsp_ready ? S_IDLE : S_RESP;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ID_W'(NUM_REQ - 1);
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (hs) begin
      last_q <= gnt_idx;
      id_q <= gnt_idx;
      a_q <= sel_a;
      b_q <= sel_b;
      op_q <= sel_op;
      if (fault) begin
        res_q <= '0;
        exc_q <= 1'b1;
        zero_q <= 1'b1;
      end
    end else if (state_q == S_EXEC) begin
      res_q <= bus_if.alu_result;
      exc_q <= bus_if.alu_exception;
      zero_q <= ~|bus_if.alu_result;
    end
  end
  always_comb begin
    bus_if.req_ready = (state_q == S_IDLE && rst_n) ? gnt_oh : '0;
    bus_if.alu_a = a_q;
    bus_if.alu_b = b_q;
    bus_if.alu_op = state_q == S_EXEC ? op_q : '0;
    bus_if.rsp_valid = state_q == S_RESP;
    bus_if.rsp_id = id_q;
    bus_if.rsp_result = res_q;
    bus_if.rsp_exception = exc_q;
    bus_if.rsp_zero = zero_q;
  end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed table, corner sequences and randomized model check
module tb_alu_rr_scheduler;
  import alu_pkg::*;
  localparam int N = 2;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_rr_scheduler_if #(.NUM_REQ(N), .DATA_W(W), .OP_W(4)) bus ();
  alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(W), .OP_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));
  int n_chk = 0;
  int n_pass = 0;
  function automatic logic [32:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    logic e;
    r = '0;
    e = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; e = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB: begin r = a - b; e = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_MUL: r = a * b;
      OP_DIV: r = (b == 0) ? 32'd0 : a / b;
      OP_SLL: r = a << b[4:0];
      OP_SLT: r = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'd0, a < b};
      OP_AND: r = a & b;
      OP_OR: r = a | b;
      OP_SRL: r = a >> b[4:0];
      OP_SRA: r = $signed(a) >>> b[4:0];
      OP_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {e, r};
  endfunction
  always_comb {bus.alu_exception, bus.alu_result} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [N-1:0] rr_pick(logic [N-1:0] v, int last);
    logic [N-1:0] r;
    r = '0;
    for (int k = 1; k <= N; k++) if (v[(last + k) % N] && r == '0) r[(last + k) % N] = 1'b1;
    return r;
  endfunction
  typedef struct {
    int rid;
    logic [31:0] a, b;
    logic [3:0] op;
    logic [31:0] res;
    logic exc, zero;
    int lat;
  } vec_t;
  vec_t tbl[11];
  task automatic set_lane(input int rid, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.req_a[rid*W +: W] = a;
    bus.req_b[rid*W +: W] = b;
    bus.req_op[rid*4 +: 4] = op;
  endtask
  task automatic run_one(input vec_t v);
    logic [N-1:0] oh;
    oh = '0;
    oh[v.rid] = 1'b1;
    @(negedge clk);
    bus.req_a = {$urandom, $urandom};
    bus.req_b = {$urandom, $urandom};
    bus.req_op = 8'($urandom);
    set_lane(v.rid, v.a, v.b, v.op);
    bus.req_valid = oh;
    #1 chk("accept_ready", 32'(bus.req_ready), 32'(oh));
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("exec_alu_op", 32'(bus.alu_op), 32'(v.lat == 2 ? v.op : 4'h0));
    if (v.lat == 2) begin
      chk("exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      #1;
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(v.rid));
    chk("rsp_result", bus.rsp_result, v.res);
    chk("rsp_exception", 32'(bus.rsp_exception), 32'(v.exc));
    chk("rsp_zero", 32'(bus.rsp_zero), 32'(v.zero));
  endtask
  initial begin
    logic [N-1:0] exp_ready;
    logic [31:0] m_a, m_b, m_res;
    logic [3:0] m_op;
    logic m_exc, m_fault, busy;
    int last, m_acc, m_lat, m_id;
    tbl[0]  = '{0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0, 1'b0, 2};
    tbl[1]  = '{1, 32'd9, 32'd9, OP_SUB, 32'd0, 1'b0, 1'b1, 2};
    tbl[2]  = '{1, 32'd100, 32'd0, OP_DIV, 32'd0, 1'b1, 1'b1, 1};
    tbl[3]  = '{0, 32'd3, 32'd4, 4'hE, 32'd0, 1'b1, 1'b1, 1};
    tbl[4]  = '{1, 32'hF0F0, 32'h0FF0, OP_AND, 32'h00F0, 1'b0, 1'b0, 2};
    tbl[5]  = '{0, 32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd1, 1'b0, 1'b0, 2};
    tbl[6]  = '{1, 32'h7FFF_FFFF, 32'd1, OP_ADD, 32'h8000_0000, 1'b1, 1'b0, 2};
    tbl[7]  = '{0, 32'd77, 32'd3, OP_NOOP, 32'd0, 1'b0, 1'b1, 2};
    tbl[8]  = '{0, 32'd100, 32'd7, OP_DIV, 32'd14, 1'b0, 1'b0, 2};
    tbl[9]  = '{0, 32'd1, 32'd4, OP_SLL, 32'd16, 1'b0, 1'b0, 2};
    tbl[10] = '{1, 32'h8000_0000, 32'd4, OP_SRA, 32'hF800_0000, 1'b0, 1'b0, 2};
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1 chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_alu_op", 32'(bus.alu_op), 32'd0);
    chk("reset_rsp_result", bus.rsp_result, 32'd0);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    foreach (tbl[i]) run_one(tbl[i]);
    // back-pressure: overflowing ADD held for 4 cycles while both requesters wait
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_lane(0, 32'h7FFF_FFFF, 32'd1, OP_ADD);
    set_lane(1, 32'd6, 32'd3, OP_XOR);
    bus.req_valid = 2'b11;
    #1 chk("bp_accept", 32'(bus.req_ready), 32'b01);
    @(negedge clk);
    #1 chk("bp_exec_op", 32'(bus.alu_op), 32'(OP_ADD));
    chk("bp_exec_ready", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_hold_result", bus.rsp_result, 32'h8000_0000);
      chk("bp_hold_exc", 32'(bus.rsp_exception), 32'd1);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1 chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    #1 chk("bp_next_grant", 32'(bus.req_ready), 32'b10);
    chk("bp_single_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("bp_xor_op", 32'(bus.alu_op), 32'(OP_XOR));
    @(negedge clk);
    #1 chk("bp_xor_result", bus.rsp_result, 32'd5);
    chk("bp_xor_id", 32'(bus.rsp_id), 32'd1);
    // reset during EXEC, then alternating grants from requester 0
    @(negedge clk);
    set_lane(1, 32'd1, 32'd1, OP_ADD);
    bus.req_valid = 2'b10;
    #1 chk("rst_accept", 32'(bus.req_ready), 32'b10);
    @(negedge clk);
    #1 chk("rst_exec_op", 32'(bus.alu_op), 32'(OP_ADD));
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1 chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    @(negedge clk);
    #1 chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    set_lane(0, 32'd10, 32'd1, OP_ADD);
    set_lane(1, 32'd10, 32'd1, OP_SUB);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1 chk("alt_ready", 32'(bus.req_ready), i % 3 == 0 ? ((i / 3) % 2 ? 32'b10 : 32'b01) : 32'd0);
      chk("alt_rsp_valid", 32'(bus.rsp_valid), 32'(i % 3 == 2));
      if (i % 3 == 2) begin
        chk("alt_rsp_id", 32'(bus.rsp_id), 32'((i / 3) % 2));
        chk("alt_rsp_result", bus.rsp_result, (i / 3) % 2 ? 32'd9 : 32'd11);
      end
    end
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // randomized traffic against a cycle-timestamp reference model
    busy = 1'b0;
    last = N - 1;
    m_acc = 0;
    m_lat = 0;
    m_id = 0;
    m_op = '0;
    m_res = '0;
    m_exc = 1'b0;
    m_fault = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.req_valid = N'($urandom_range(0, 3));
      bus.req_a = {$urandom, $urandom};
      for (int r = 0; r < N; r++) bus.req_b[r*W +: W] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      bus.req_op = 8'($urandom);
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      #1;
      exp_ready = busy ? '0 : rr_pick(bus.req_valid, last);
      chk("rand_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("rand_alu_op", 32'(bus.alu_op), 32'((busy && !m_fault && c == m_acc + 1) ? m_op : 4'h0));
      chk("rand_rsp_valid", 32'(bus.rsp_valid), 32'(busy && c >= m_acc + m_lat));
      if (busy && c >= m_acc + m_lat) begin
        chk("rand_rsp_id", 32'(bus.rsp_id), 32'(m_id));
        chk("rand_rsp_result", bus.rsp_result, m_res);
        chk("rand_rsp_exc", 32'(bus.rsp_exception), 32'(m_exc));
        chk("rand_rsp_zero", 32'(bus.rsp_zero), 32'(m_res == 0));
        if (bus.rsp_ready) busy = 1'b0;
      end else if (!busy && exp_ready != '0) begin
        for (int r = 0; r < N; r++) if (exp_ready[r]) m_id = r;
        last = m_id;
        busy = 1'b1;
        m_acc = c;
        m_a = bus.req_a[m_id*W +: W];
        m_b = bus.req_b[m_id*W +: W];
        m_op = bus.req_op[m_id*4 +: 4];
        m_fault = m_op > 4'd12 || (m_op == OP_DIV && m_b == 0);
        m_lat = m_fault ? 1 : 2;
        {m_exc, m_res} = m_fault ? {1'b1, 32'd0} : alu_fn(m_op, m_a, m_b);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Shares one combinational 32-bit MIPS-like ALU between NUM_REQ requesters. Per-requester valid/ready request channel, round-robin arbitration and operand registering. Drives the ALU for one cycle, captures result plus flags, and returns them on a single tagged response channel with back-pressure. Sits between issue logic (register-file read ports) and the shared ALU.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 32, operand/result width
OP_W, 4, opcode width
ID_W, $clog2(NUM_REQ), response tag width (minimum 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  request accepted, one-hot or zero
req_a  in  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand B, same packing
req_op  in  NUM_REQ*OP_W  opcode, same packing
alu_a  out  DATA_W  operand A to ALU
alu_b  out  DATA_W  operand B to ALU
alu_op  out  OP_W  opcode to ALU
alu_result  in  DATA_W  ALU result
alu_exception  in  1  ALU overflow exception
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of requester that issued the op
rsp_result  out  DATA_W  captured result
rsp_exception  out  1  overflow, divide-by-zero or illegal opcode
rsp_zero  out  1  rsp_result == 0

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- Reset: all outputs and registers 0; rr pointer last_grant = NUM_REQ-1, so requester 0 wins first.
- IDLE:
  - Grant = first i with req_valid[i], searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[grant] = 1, combinationally in IDLE only. All other req_ready bits are 0; all bits are 0 in EXEC and RESP.
  - On handshake (valid & ready): latch a, b, op and grant id; last_grant <= grant.
- Next state after handshake:
  - Legal op (0x0..0xC) with no divide-by-zero: go to EXEC.
  - Illegal opcode (0xD..0xF), or DIV (0x4) with b == 0: go directly to RESP with result 0 and exception 1. The ALU is not driven.
- No request: remain in IDLE.
- Requests are not sticky. Arbitration is re-evaluated every IDLE cycle, and a requester may drop valid before acceptance.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_op = latched values.
  - At end of cycle capture rsp_result <= alu_result and rsp_exception <= alu_exception; go to RESP.
- Outside EXEC: alu_op = 0 (NOOP); alu_a/alu_b hold their last latched values.
- RESP:
  - rsp_valid = 1. rsp_id/result/exception/zero are stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
- rsp_zero is registered alongside rsp_result. It equals ~|result, including the forced-zero exception cases.
- Latency: accept at cycle N gives rsp_valid at N+2 (N+1 for fault bypass). Minimum 3 cycles per op with rsp_ready held high.
- Response cycle and new acceptance never overlap, since req_ready is IDLE-only.
- Reset mid-operation clears the in-flight op with no response. A requester still holding valid is re-arbitrated from requester 0.
- NOOP (0x0) is legal: goes through EXEC and returns whatever the ALU yields for NOOP.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants: NOOP=0, ADD=1, SUB=2, MUL=3, DIV=4, SLL=5, SLT=6, SLTU=7, AND=8, OR=9, SRL=10, SRA=11, XOR=12, OP_LAST=12.
  - FSM state encoding.
  - DATA_W/OP_W defaults.
- One sub-module, rr_arbiter: parameter NUM_REQ; inputs req vector and last_grant; outputs one-hot grant and grant index. Purely combinational. The pointer register lives in alu_rr_scheduler.

Test Plan:
1. Single requester 0: a=5, b=7, op=ADD, rsp_ready=1. Expect req_ready[0] in accept cycle; alu_op=1 exactly one cycle later; rsp_valid two cycles after accept with id=0, result=12, exception=0, zero=0.
2. Both requesters valid continuously, distinct ops. Expect grants 0,1,0,1 alternating. Each rsp_id matches its operands; one response every 3 cycles.
3. DIV with b=0 from requester 1. Expect rsp_valid one cycle after accept, result=0, exception=1, zero=1, alu_op stays 0 throughout.
4. op=0xE (illegal). Expect same fault-bypass response as 3 with id of sender; following legal op is processed normally.
5. Model alu_exception=1 for ADD 0x7FFFFFFF+1 with rsp_ready=0 for 4 cycles. Expect rsp_valid held, outputs stable, req_ready all 0. Release gives one response and return to IDLE.
6. Assert rst_n low during EXEC. Expect rsp_valid=0, req_ready=0 immediately. After release with requesters 0 and 1 valid, requester 0 is granted first.
